if_fetch_unit: RTL and testbench

Instruction-fetch stage that drives the instruction ROM port (chip-enable, word address) and hands fetched instructions to the decode stage. Holds the program counter, keeps up to one ROM request in flight, buffers responses in a 2-entry {pc, inst} queue so decode stalls never lose an instruction, and handles branch redirects by discarding stale fetches. Sits between the pipeline control/ID stage (downstream) and the ROM driver (upstream data source).

---
 rtl/if_fetch_unit_pkg.sv | 38 +++
 rtl/if_fetch_fifo.sv | 64 ++++++
 rtl/if_fetch_unit.sv | 138 +++++++++++++
 tb/tb_if_fetch_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg -- shared definitions for the instruction-fetch stage.
//
// Provides the bus-width / constant macros used across the fetch slice
// (`RomAddrBus, `InstBus, `ZeroWord, `ChipEnable/`ChipDisable, `RstEnable,
// `IfIdle/`IfRun/`IfHalt), the fetch FSM state type, and a word-alignment
// helper. Compile this file before the other fetch files.
//
// Optional feature: FETCH_ALIGN_CHECK_EN (see if_fetch_unit.sv).

`ifndef IF_FETCH_DEFINES_SVH
`define IF_FETCH_DEFINES_SVH
`define RomAddrBus  31:0
`define InstBus     31:0
`define ZeroWord    32'h0000_0000
`define ChipEnable  1'b1
`define ChipDisable 1'b0
`define RstEnable   1'b1
`define IfIdle      2'b00
`define IfRun       2'b01
`define IfHalt      2'b10
`endif

package if_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IF_IDLE = `IfIdle,
        IF_RUN  = `IfRun,
        IF_HALT = `IfHalt
    } fetch_state_e;

    localparam int unsigned QUEUE_DEPTH = 2;

    // Drop the byte-offset bits of a redirect target.
    function automatic logic [`RomAddrBus] align_word(input logic [`RomAddrBus] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// if_fetch_fifo -- 2-entry {pc, inst} queue between fetch and decode.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, push_pc,
//   push_inst         enqueue one fetched instruction
//   pop               dequeue the head (ignored when empty)
//   clear             flush all entries (wins over push/pop)
//   count             number of valid entries (0..2)
//   head_valid,
//   head_pc,
//   head_inst         queue head; pc/inst read as zero when empty

import if_fetch_unit_pkg::*;

module if_fetch_fifo (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [`RomAddrBus] push_pc,
    input  logic [`InstBus]    push_inst,
    input  logic              pop,
    input  logic              clear,
    output logic [1:0]        count,
    output logic              head_valid,
    output logic [`RomAddrBus] head_pc,
    output logic [`InstBus]    head_inst
);

    logic [`RomAddrBus] pc_mem   [QUEUE_DEPTH];
    logic [`InstBus]    inst_mem [QUEUE_DEPTH];
    logic               wr_ptr;
    logic               rd_ptr;

    // NOTE: only the pointers and count are reset; the storage array is
    // qualified by count, so resetting it would add reset fan-out for nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == `RstEnable) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            pc_mem[wr_ptr]   <= push_pc;
            inst_mem[wr_ptr] <= push_inst;
        end
    end

    assign head_valid = (count != 2'd0);
    assign head_pc    = head_valid ? pc_mem[rd_ptr]   : `ZeroWord;
    assign head_inst  = head_valid ? inst_mem[rd_ptr] : `ZeroWord;

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit -- instruction-fetch stage.
//
// Holds the PC, keeps at most one ROM request in flight, and buffers
// responses in a 2-entry queue so decode stalls never drop an instruction.
// A redirect flushes the queue and discards any response arriving with it.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   stall                        decode cannot take the head this cycle
//   branch_flag_i/_target_i      redirect request and address
//   rom_ce, rom_addr             ROM request (combinational)
//   rom_inst, rom_ack            ROM response, one cycle after the request
//   if_valid, if_pc, if_inst     queue head to decode
//   fetch_fault                  misaligned redirect seen
//
// Macro FETCH_ALIGN_CHECK_EN: when defined, a misaligned redirect target
// parks the stage in HALT with fetch_fault set until an aligned redirect.
// When undefined, target bits [1:0] are forced to zero and fetch_fault is 0.

import if_fetch_unit_pkg::*;

module if_fetch_unit #(
    parameter logic [`RomAddrBus] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_flag_i,
    input  logic [`RomAddrBus] branch_target_i,
    output logic               rom_ce,
    output logic [`RomAddrBus] rom_addr,
    input  logic [`InstBus]    rom_inst,
    input  logic               rom_ack,
    output logic               if_valid,
    output logic [`RomAddrBus] if_pc,
    output logic [`InstBus]    if_inst,
    output logic               fetch_fault
);

    fetch_state_e       state;
    logic [`RomAddrBus] pc;
    logic [`RomAddrBus] req_pc;
    logic               inflight;
    logic [1:0]         count;
    logic               push;
    logic               pop;
    logic               issue_new;
    logic               replay;
    logic [2:0]         occupancy;

    // A redirect drops the response arriving with it and freezes the head.
    assign push = inflight & rom_ack & ~branch_flag_i;
    assign pop  = if_valid & ~stall & ~branch_flag_i;

    // Slots already committed after this edge: queued entries plus the
    // outstanding request, minus the entry decode takes now. Keeping this
    // below the depth guarantees every response has somewhere to land.
    assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

    // NOTE: every variable assigned here gets a default first so no latch
    // is inferred on paths that do not drive it.
    always_comb begin
        issue_new = 1'b0;
        replay    = 1'b0;
        if (state == IF_RUN && !branch_flag_i) begin
            if (inflight && !rom_ack)
                replay = 1'b1;
            else if (occupancy < 3'd2)
                issue_new = 1'b1;
        end
    end

    assign rom_ce   = (issue_new || replay) ? `ChipEnable : `ChipDisable;
    assign rom_addr = replay ? req_pc : (issue_new ? pc : `ZeroWord);

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q;
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == `RstEnable) begin
            state    <= IF_IDLE;
            pc       <= RESET_PC;
            req_pc   <= `ZeroWord;
            inflight <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q  <= 1'b0;
`endif
        end else if (branch_flag_i) begin
            inflight <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            if (branch_target_i[1:0] != 2'b00) begin
                state   <= IF_HALT;
                fault_q <= 1'b1;
            end else begin
                state   <= IF_RUN;
                fault_q <= 1'b0;
                pc      <= branch_target_i;
            end
`else
            state <= IF_RUN;
            pc    <= align_word(branch_target_i);
`endif
        end else begin
            case (state)
                IF_IDLE: state <= IF_RUN;
                IF_RUN: begin
                    if (issue_new) begin
                        pc     <= pc + 32'd4;
                        req_pc <= pc;
                    end
                    inflight <= issue_new | replay;
                end
                default: inflight <= 1'b0;  // HALT: no requests
            endcase
        end
    end

    if_fetch_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_pc    (req_pc),
        .push_inst  (rom_inst),
        .pop        (pop),
        .clear      (branch_flag_i),
        .count      (count),
        .head_valid (if_valid),
        .head_pc    (if_pc),
        .head_inst  (if_inst)
    );

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit -- directed bench for if_fetch_unit.
//
// The ROM model answers each request one cycle later with
// inst = addr ^ 32'hDEAD_0000. Inputs change #1 after the rising edge and
// outputs are compared #2 after it, well away from the next edge.

module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        rom_ack;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        fetch_fault;

    logic [31:0] last_addr = 32'h0;
    int          n_checks  = 0;
    int          n_fail    = 0;

    always #5 clk = ~clk;

    always @(posedge clk) last_addr <= rom_addr;
    assign rom_inst = last_addr ^ 32'hDEAD_0000;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .rom_ce          (rom_ce),
        .rom_addr        (rom_addr),
        .rom_inst        (rom_inst),
        .rom_ack         (rom_ack),
        .if_valid        (if_valid),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .fetch_fault     (fetch_fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are updated.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; branch_flag_i = 1'b0;
        branch_target_i = 32'h0; rom_ack = 1'b1;
        next_cycle(); next_cycle();

        // cycle 0: reset released, IDLE
        rst = 1'b0; settle();
        check("c0_rom_ce", 32'(rom_ce), 32'd0);
        check("c0_rom_addr", rom_addr, 32'h0);
        check("c0_if_valid", 32'(if_valid), 32'd0);
        check("c0_if_pc", if_pc, 32'h0);
        check("c0_if_inst", if_inst, 32'h0);
        check("c0_fault", 32'(fetch_fault), 32'd0);
        next_cycle(); settle();
        // cycle 1..5: streaming
        check("c1_rom_ce", 32'(rom_ce), 32'd1);
        check("c1_rom_addr", rom_addr, 32'h0);
        next_cycle(); settle();
        check("c2_rom_addr", rom_addr, 32'h4);
        check("c2_if_valid", 32'(if_valid), 32'd0);
        next_cycle(); settle();
        check("c3_rom_addr", rom_addr, 32'h8);
        check("c3_if_valid", 32'(if_valid), 32'd1);
        check("c3_if_pc", if_pc, 32'h0);
        check("c3_if_inst", if_inst, 32'hDEAD_0000);
        next_cycle(); settle();
        check("c4_if_pc", if_pc, 32'h4);
        check("c4_if_inst", if_inst, 32'hDEAD_0004);
        check("c4_rom_addr", rom_addr, 32'hC);

        // cycles 5..9: stall
        next_cycle(); stall = 1'b1; settle();
        check("c5_if_pc", if_pc, 32'h8);
        check("c5_rom_ce", 32'(rom_ce), 32'd0);
        next_cycle(); settle();
        next_cycle(); settle();
        check("c7_rom_ce", 32'(rom_ce), 32'd0);
        check("c7_if_pc", if_pc, 32'h8);
        next_cycle(); settle();
        next_cycle(); settle();
        check("c9_if_pc", if_pc, 32'h8);
        // cycle 10: release
        next_cycle(); stall = 1'b0; settle();
        check("c10_rom_ce", 32'(rom_ce), 32'd1);
        check("c10_rom_addr", rom_addr, 32'h10);
        check("c10_if_pc", if_pc, 32'h8);

        // cycles 11..13: ROM withholds ack for 0x10
        next_cycle(); rom_ack = 1'b0; settle();
        check("c11_if_pc", if_pc, 32'hC);
        check("c11_rom_addr", rom_addr, 32'h10);
        next_cycle(); settle();
        check("c12_if_valid", 32'(if_valid), 32'd0);
        check("c12_rom_ce", 32'(rom_ce), 32'd1);
        check("c12_rom_addr", rom_addr, 32'h10);
        next_cycle(); settle();
        check("c13_rom_addr", rom_addr, 32'h10);
        next_cycle(); rom_ack = 1'b1; settle();
        check("c14_rom_addr", rom_addr, 32'h14);
        next_cycle(); settle();
        check("c15_if_pc", if_pc, 32'h10);
        check("c15_if_inst", if_inst, 32'hDEAD_0010);
        check("c15_rom_addr", rom_addr, 32'h18);

        // cycle 16: redirect to 0x100 with entry queued and 0x18 acked
        next_cycle(); branch_flag_i = 1'b1; branch_target_i = 32'h100; settle();
        check("c16_if_pc", if_pc, 32'h14);
        check("c16_rom_ce", 32'(rom_ce), 32'd0);
        next_cycle(); branch_flag_i = 1'b0; settle();
        check("c17_if_valid", 32'(if_valid), 32'd0);
        check("c17_rom_addr", rom_addr, 32'h100);
        next_cycle(); settle();
        check("c18_if_valid", 32'(if_valid), 32'd0);
        check("c18_rom_addr", rom_addr, 32'h104);
        next_cycle(); settle();
        check("c19_if_pc", if_pc, 32'h100);
        check("c19_if_inst", if_inst, 32'hDEAD_0100);
        next_cycle(); settle();
        check("c20_if_pc", if_pc, 32'h104);

        // cycles 20..21: fill queue under stall, then redirect with stall held
        stall = 1'b1;
        next_cycle(); branch_flag_i = 1'b1; branch_target_i = 32'h200; settle();
        check("c21_rom_ce", 32'(rom_ce), 32'd0);
        check("c21_if_pc", if_pc, 32'h104);
        next_cycle(); branch_flag_i = 1'b0; stall = 1'b0; settle();
        check("c22_if_valid", 32'(if_valid), 32'd0);
        check("c22_rom_addr", rom_addr, 32'h200);
        next_cycle(); settle();
        next_cycle(); settle();
        check("c24_if_pc", if_pc, 32'h200);
        check("c24_if_inst", if_inst, 32'hDEAD_0200);

        // misaligned redirect to 0x102
        next_cycle(); branch_flag_i = 1'b1; branch_target_i = 32'h102; settle();
        next_cycle(); branch_flag_i = 1'b0; settle();
`ifdef FETCH_ALIGN_CHECK_EN
        check("mis_fault", 32'(fetch_fault), 32'd1);
        check("mis_rom_ce", 32'(rom_ce), 32'd0);
        check("mis_if_valid", 32'(if_valid), 32'd0);
        next_cycle(); settle();
        next_cycle(); settle();
        check("halt_rom_ce", 32'(rom_ce), 32'd0);
        check("halt_fault", 32'(fetch_fault), 32'd1);
        next_cycle(); branch_flag_i = 1'b1; branch_target_i = 32'h200; settle();
        next_cycle(); branch_flag_i = 1'b0; settle();
        check("rec_fault", 32'(fetch_fault), 32'd0);
        check("rec_rom_ce", 32'(rom_ce), 32'd1);
        check("rec_rom_addr", rom_addr, 32'h200);
`else
        check("mis_fault", 32'(fetch_fault), 32'd0);
        check("mis_rom_ce", 32'(rom_ce), 32'd1);
        check("mis_rom_addr", rom_addr, 32'h100);
`endif

        // asynchronous reset mid-stream
        next_cycle(); next_cycle();
        #2 rst = 1'b1; #1;
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_rom_ce", 32'(rom_ce), 32'd0);
        check("rst_if_pc", if_pc, 32'h0);
        next_cycle(); rst = 1'b0; settle();
        check("rst_idle_rom_ce", 32'(rom_ce), 32'd0);
        next_cycle(); settle();
        check("rst_first_addr", rom_addr, 32'h0);
        check("rst_first_ce", 32'(rom_ce), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
